sync_fifo_ctrl: RTL

//  Single-clock FIFO controller that sequences one instance of the team's

---
 rtl/sync_fifo_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: sequences a dual-port RAM, tracks occupancy and
// drives registered status flags plus a read-valid strobe matched to the RAM read mode.
module sync_fifo_ctrl #(
    parameter int unsigned ADDR_SIZE   = 4,
    parameter int unsigned AFULL_TH    = 12,
    parameter int unsigned AEMPTY_TH   = 2,
    parameter string       SHOW_AHAEAD = "ON"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 clr,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_wr_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_SIZE-1:0] mem_rd_addr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   usedw,
    output logic                 rd_valid,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned     PW        = ADDR_SIZE + 1;
    localparam logic [PW-1:0]   DepthW    = PW'(1 << ADDR_SIZE);
    localparam logic [PW-1:0]   AfullW    = PW'(AFULL_TH);
    localparam logic [PW-1:0]   AemptyW   = PW'(AEMPTY_TH);
    localparam logic [PW-1:0]   PtrOne    = PW'(1);
    localparam bit              ShowAhead = (SHOW_AHAEAD == "ON");

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] usedw_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_acc, rd_acc;

    // Acceptance is judged on registered flags, so a full FIFO still takes a read
    // but drops the same-cycle write (and vice versa when empty).
    assign wr_acc = wr_req & ~full_q & ~clr;
    assign rd_acc = rd_req & ~empty_q & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
        end
        usedw_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (usedw_d == DepthW);
        empty_d  = (usedw_d == '0);
        afull_d  = (usedw_d >= AfullW);
        aempty_d = (usedw_d <= AemptyW);
        ovf_d    = ~clr & (ovf_q | (wr_req & full_q));
        udf_d    = ~clr & (udf_q | (rd_req & empty_q));
        // Registered-read RAMs present data one cycle after the accepted read.
        rd_valid_d = ShowAhead ? ~empty_d : rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign mem_wr_en    = wr_acc;
    assign mem_wr_addr  = wr_ptr_q[ADDR_SIZE-1:0];
    assign mem_rd_en    = rd_acc;
    assign mem_rd_addr  = rd_ptr_q[ADDR_SIZE-1:0];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign usedw        = wr_ptr_q - rd_ptr_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
